// File: rtl/icap_iprog_ctrl.sv
// icap_iprog_ctrl
// Turns a one-cycle start pulse into the 8-word ICAPE2 IPROG command sequence.
// The sequence programs WBSTAR with a latched warm-boot address and then issues IPROG.
// The ICAPE2 pins CSIB, RDWRB and I are driven straight from registers.
// Build option: define ICAP_BITSWAP_EN to bit-reverse every byte of icap_i.
// Leave it undefined when the primitive wrapper already does that swap.
// SETUP_CYCLES must be in 1..15 because the setup counter is 4 bits wide.

module icap_iprog_ctrl #(
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] wbstar_addr,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        FINISH
    } state_t;

    // Counter is loaded with N-1 so SETUP lasts exactly N cycles.
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [31:0] addr_q;
    logic        csib_q;
    logic        rdwrb_q;
    logic [31:0] data_q;
    logic        busy_q;
    logic        done_q;

    logic [2:0]  sel_d;
    logic [31:0] raw_d;
    logic [31:0] word_d;

    // Pick the word that goes on the bus in the next cycle.
    // Word 0 is queued when SETUP ends; after that it is the word after the current one.
    always_comb begin
        sel_d = (state_q == SETUP) ? 3'd0 : idx_q + 3'd1;
        raw_d = 32'h0000_0000;
        case (sel_d)
            3'd0: raw_d = 32'hFFFF_FFFF;   // dummy
            3'd1: raw_d = 32'hAA99_5566;   // sync
            3'd2: raw_d = 32'h2000_0000;   // NOOP
            3'd3: raw_d = 32'h3002_0001;   // write WBSTAR
            3'd4: raw_d = addr_q;          // warm-boot address
            3'd5: raw_d = 32'h3000_8001;   // write CMD
            3'd6: raw_d = 32'h0000_000F;   // IPROG
            3'd7: raw_d = 32'h2000_0000;   // NOOP
            default: raw_d = 32'h0000_0000;
        endcase
    end

`ifdef ICAP_BITSWAP_EN
    // ICAPE2 expects bit 0 and bit 7 swapped within every byte.
    genvar gi;
    for (gi = 0; gi < 32; gi++) begin : g_swap
        assign word_d[gi] = raw_d[(gi / 8) * 8 + 7 - (gi % 8)];
    end
`else
    // The primitive wrapper does the byte swap, so words go out unchanged.
    assign word_d = raw_d;
`endif

    // Sequencing FSM with all ICAPE2 pins and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            addr_q  <= 32'h0000_0000;
            csib_q  <= 1'b1;
            rdwrb_q <= 1'b1;
            data_q  <= 32'h0000_0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A start in any other state falls through unseen, so it is never queued.
                    if (start) begin
                        state_q <= SETUP;
                        addr_q  <= wbstar_addr;
                        cnt_q   <= SETUP_LOAD;
                        rdwrb_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    // RDWRB is already low while CSIB is still high.
                    if (cnt_q == 4'd0) begin
                        state_q <= WRITE;
                        idx_q   <= 3'd0;
                        csib_q  <= 1'b0;
                        data_q  <= word_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WRITE: begin
                    if (idx_q == 3'd7) begin
                        state_q <= HOLD;
                        csib_q  <= 1'b1;
                        data_q  <= 32'h0000_0000;
                    end else begin
                        idx_q  <= idx_q + 3'd1;
                        data_q <= word_d;
                    end
                end
                HOLD: begin
                    // CSIB went high in the previous cycle, so RDWRB may rise now.
                    state_q <= FINISH;
                    rdwrb_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    csib_q  <= 1'b1;
                    rdwrb_q <= 1'b1;
                    data_q  <= 32'h0000_0000;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign icap_csib  = csib_q;
    assign icap_rdwrb = rdwrb_q;
    assign icap_i     = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_icap_iprog_ctrl.sv
// Scoreboard bench for icap_iprog_ctrl.
// Two instances run side by side, one with SETUP_CYCLES=1 and one with SETUP_CYCLES=4.
// Both share the same start, address and reset stimulus.
// Each accepted start pushes its expected word writes and done pulse into a per-instance queue.
// A negedge monitor pops that queue whenever the DUT drives CSIB low or pulses done.

module tb_icap_iprog_ctrl;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] wbstar_addr = 32'h0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Cycle number = number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", name, inst, cyc, got, want);
        end
    endtask

    // Expected bus word k of a sequence, as seen on icap_i.
    function automatic logic [31:0] exp_word(input int k, input logic [31:0] addr);
        logic [31:0] list [8];
        logic [31:0] w;
        logic [7:0]  b;
        logic [31:0] r;
        list = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                 32'h00000000, 32'h30008001, 32'h0000000F, 32'h20000000};
        w = (k == 4) ? addr : list[k];
`ifdef ICAP_BITSWAP_EN
        for (int j = 0; j < 4; j++) begin
            b = w[8*j +: 8];
            r[8*j +: 8] = {<<{b}};
        end
`else
        r = w;
`endif
        return r;
    endfunction

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_inst
        localparam int S = (gi == 0) ? 1 : 4;

        logic        csib;
        logic        rdwrb;
        logic [31:0] data;
        logic        busy;
        logic        done;

        ev_t exp_q[$];
        int  bs = 1;
        int  be = 0;

        icap_iprog_ctrl #(.SETUP_CYCLES(S)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .wbstar_addr(wbstar_addr),
            .icap_csib  (csib),
            .icap_rdwrb (rdwrb),
            .icap_i     (data),
            .busy       (busy),
            .done       (done)
        );

        // Reference model: a start seen in a cycle after the previous busy span is accepted.
        // It produces S setup cycles, 8 words, 1 hold cycle and 1 done cycle.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                exp_q.delete();
                bs = 1;
                be = 0;
            end else if (start && cyc > be) begin
                bs = cyc + 1;
                be = cyc + S + 10;
                for (int k = 0; k < 8; k++)
                    exp_q.push_back('{cyc + S + 1 + k, 1'b0, exp_word(k, wbstar_addr)});
                exp_q.push_back('{cyc + S + 10, 1'b1, 32'h0});
                $display("inst%0d sequence accepted cyc=%0d addr=%h done_due=%0d", gi, cyc, wbstar_addr, be);
            end
        end

        // Monitor: compare status every cycle and pop scoreboard events when the bus is active.
        always @(negedge clk) begin
            bit   exp_busy;
            bit   exp_rdwrb;
            ev_t  e;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_event", gi, 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            exp_busy  = (cyc >= bs) && (cyc <= be);
            exp_rdwrb = !((cyc >= bs) && (cyc < be));
            chk("busy", gi, 32'(busy), 32'(exp_busy));
            chk("rdwrb", gi, 32'(rdwrb), 32'(exp_rdwrb));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (e.is_done) begin
                    chk("done_pulse", gi, {30'b0, csib, done}, 32'h3);
                end else begin
                    chk("write_ctl", gi, {30'b0, csib, done}, 32'h0);
                    chk("write_word", gi, data, e.data);
                end
            end else begin
                chk("bus_quiet", gi, {30'b0, csib, done}, 32'h2);
            end
            if (!exp_busy)
                chk("idle_data", gi, data, 32'h0);
        end
    end

    task automatic check_reset_values(input string name);
        chk(name, 0, {28'b0, g_inst[0].csib, g_inst[0].rdwrb, g_inst[0].busy, g_inst[0].done}, 32'hC);
        chk(name, 0, g_inst[0].data, 32'h0);
        chk(name, 1, {28'b0, g_inst[1].csib, g_inst[1].rdwrb, g_inst[1].busy, g_inst[1].done}, 32'hC);
        chk(name, 1, g_inst[1].data, 32'h0);
    endtask

    initial begin
        int t0;

        // Reset, then 100 idle cycles with no start.
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // Directed 0x00400000 sequence with ignored pulses at T+3 and at both done cycles.
        @(negedge clk);
        start = 1'b1;
        wbstar_addr = 32'h0040_0000;
        t0 = cyc;
        while (cyc < t0 + 40) begin
            @(negedge clk);
            start = (cyc == t0 + 3) || (cyc == t0 + 11) || (cyc == t0 + 14);
            wbstar_addr = $urandom;
        end

        // Asynchronous reset during word 5 of the SETUP_CYCLES=1 instance.
        @(negedge clk);
        start = 1'b1;
        wbstar_addr = 32'h1234_5678;
        t0 = cyc;
        while (cyc < t0 + 7) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A clean full sequence after reset.
        @(negedge clk);
        start = 1'b1;
        wbstar_addr = 32'h00C0_FFEE;
        t0 = cyc;
        while (cyc < t0 + 30) begin
            @(negedge clk);
            start = 1'b0;
            wbstar_addr = $urandom;
        end

        // Random start pulses and addresses.
        repeat (600) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            wbstar_addr = $urandom;
        end

        // Drain and confirm every expected event was seen.
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("queue_drain", 0, 32'(g_inst[0].exp_q.size()), 32'h0);
        chk("queue_drain", 1, 32'(g_inst[1].exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icap_iprog_ctrl.md
# icap_iprog_ctrl

- Consumes the one-cycle `start` pulse from the debounced-key stage.
- On each accepted pulse, issues the 8-word IPROG command sequence to the Artix-7 ICAPE2 primitive, writing the WBSTAR warm-boot address first so the device reconfigures from that flash address.
- Sits between the key-filter stage and the ICAPE2 instance; drives CSIB, RDWRB and I directly.
- Reports progress with `busy` and a `done` pulse.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles RDWRB is held low with CSIB high before the first write word; legal range 1..15.

Ports:
- clk  input  1  system clock, also drives ICAPE2 CLK.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse from the debounce stage.
- wbstar_addr  input  32  warm-boot start address, sampled in the cycle `start` is accepted.
- icap_csib  output  1  ICAPE2 chip select, active low; reset 1.
- icap_rdwrb  output  1  ICAPE2 direction, 0 = write; reset 1.
- icap_i  output  32  ICAPE2 data word; reset 0.
- busy  output  1  high while a sequence is in progress; reset 0.
- done  output  1  one-cycle pulse at the end of a sequence; reset 0.

## Operation
- All outputs are registered.
- FSM states: IDLE, SETUP, WRITE, HOLD, FINISH.
- IDLE:
  - csib=1, rdwrb=1, icap_i=0, busy=0.
  - When `start`=1: latch wbstar_addr, load the setup counter, go to SETUP.
- SETUP:
  - rdwrb=0, csib=1, busy=1.
  - Stays for SETUP_CYCLES cycles, then goes to WRITE with word index 0.
- WRITE:
  - csib=0, rdwrb=0.
  - icap_i = word[idx], idx increments every cycle, 3-bit index over 8 words.
  - After idx=7 goes to HOLD.
- Word list, before bit swap:
  - 0: 0xFFFFFFFF (dummy)
  - 1: 0xAA995566 (sync)
  - 2: 0x20000000 (NOOP)
  - 3: 0x30020001 (write WBSTAR)
  - 4: latched wbstar_addr
  - 5: 0x30008001 (write CMD)
  - 6: 0x0000000F (IPROG)
  - 7: 0x20000000 (NOOP)
- HOLD: csib=1, rdwrb=0, icap_i=0, for 1 cycle.
- FINISH: rdwrb=1, done=1, busy=1, for 1 cycle, then IDLE.
- `start` pulses in any state other than IDLE are ignored and are not queued.
- A changing wbstar_addr during a sequence has no effect; only the latched value is used.
- Asynchronous reset at any point, including mid-WRITE, immediately forces IDLE with all outputs at their reset values. No partial sequence resumes after reset.

## Timing
- `start` sampled high at edge T:
  - From T+1 for SETUP_CYCLES cycles: rdwrb=0.
  - Then 8 consecutive cycles of csib=0, one word per cycle, no gaps.
  - Then 1 HOLD cycle, then 1 FINISH cycle with done=1.
  - From the following cycle: back in IDLE.
- Total sequence length: SETUP_CYCLES + 10 cycles. busy is high for the whole span.
- rdwrb changes only while csib=1; it never toggles in a cycle where csib=0.
- A new `start` is accepted no earlier than the first IDLE cycle after FINISH. A `start` coincident with done=1 is ignored.

## Configuration
- ICAP_BITSWAP_EN defined:
  - Each byte of icap_i is bit-reversed, per the ICAPE2 data convention (bit 0 ↔ bit 7 within every byte).
  - Example: 0xAA995566 is output as 0x5599AA66.
- ICAP_BITSWAP_EN undefined:
  - Words are output unswapped.
  - Used when the swap is done at the primitive wrapper.
- Sequencing and timing are identical in both builds.

## Test plan
- Reset release, no start: csib=1, rdwrb=1, icap_i=0, busy=0, done=0 held for 100 cycles.
- start with wbstar_addr=0x00400000, ICAP_BITSWAP_EN defined, SETUP_CYCLES=1: I words in order FFFFFFFF, 5599AA66, 04000000, 0C40800 0→ 0x0C400080, 00020000, 0C000180, 000000F0, 04000000. done asserted at T+11.
- Same stimulus with the macro undefined: raw list with word 4 = 0x00400000. Sequence length unchanged.
- start pulses at T+3 and at the done cycle: ignored. Exactly 8 csib-low cycles, one done pulse.
- rst_n asserted during word 5: outputs return to reset values asynchronously. A later start produces a full clean 8-word sequence.
- SETUP_CYCLES=4: rdwrb low 4 cycles before csib falls; done at T+14.
